rr_arbiter_2_to_1: RTL and testbench
====================================

Name: rr_arbiter_2_to_1

Overview:
- Two-input round-robin stream arbiter with a registered output stage.
- Sits directly upstream of the 2:1 select mux.
- Grants one of two valid/ready sources per cycle and produces the registered `sel` that steers the mux, plus the selected data word.
- Keeps per-source grant counters for fairness checks.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- CNT_W, 8, width of each per-source grant counter (wraps).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in1_valid  input  1  source 1 has a word.
- in1_data  input  WIDTH  source 1 word.
- in1_ready  output  1  source 1 word accepted this cycle.
- in2_valid  input  1  source 2 has a word.
- in2_data  input  WIDTH  source 2 word.
- in2_ready  output  1  source 2 word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_ready  input  1  downstream accepts out_data this cycle.
- sel  output  1  source of word in output register: 0 = in1, 1 = in2; drives the mux select.
- grant_cnt1  output  CNT_W  number of words accepted from source 1, mod 2^CNT_W.
- grant_cnt2  output  CNT_W  number of words accepted from source 2, mod 2^CNT_W.

Behaviour:
- Reset, sampled on the rising clk edge while rst_n = 0:
  - out_valid = 0, out_data = 0, sel = 0, prio = 0 (in1 favoured), grant_cnt1 = grant_cnt2 = 0.
  - in1_ready = in2_ready = 0 for the whole cycle in which rst_n = 0.
- can_load = !out_valid || out_ready. Combinational; ready paths may depend combinationally on out_ready.
- Grant is combinational:
  - Only in1_valid: grant in1.
  - Only in2_valid: grant in2.
  - Both valid: grant in1 if prio = 0, else in2.
  - Neither valid: no grant.
- inN_ready = can_load && (grant is N). Never more than one ready high in a cycle. A ready is never high for a source whose valid is low.
- Transfer on source N occurs when inN_valid && inN_ready. On the next edge:
  - out_data <= inN_data, sel <= N-1, out_valid <= 1.
  - prio <= (N == 1 ? 1 : 0), i.e. priority moves to the other source.
  - grant_cntN increments.
- prio updates only on a transfer. A single-source grant also flips it.
- Output drain without refill: out_valid && out_ready with no input transfer gives out_valid <= 0. out_data and sel hold their last values.
- Simultaneous drain and refill in one cycle: out_valid stays 1 and the new word loads. Sustained full throughput is one word per cycle.
- Stall: while out_valid && !out_ready, out_data and sel hold stable, both readies are 0, and prio and counters hold.
- Latency: an accepted word appears on out_data/out_valid exactly 1 cycle after its transfer cycle.
- Counters wrap from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: a word held in the output register is discarded. No transfer is counted in the reset cycle even if valids are high. Arbitration restarts with in1 favoured.
- Input data is not required to be stable while inN_valid && !inN_ready. The arbiter does not check source valid-hold protocol.
- No X propagation requirement on out_data while out_valid = 0 beyond the reset value of 0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with in1_valid=in2_valid=1 -> both readies 0 throughout. After release: out_valid=0, sel=0, counters 0.
- Single source: in1 streams 0x11,0x22,0x33 with out_ready=1 -> in1_ready=1 each cycle. out_data shows 0x11,0x22,0x33 one cycle later with sel=0. grant_cnt1=3, grant_cnt2=0.
- Contention: both valid continuously, in1_data=0xA0, in2_data=0xB0, out_ready=1 -> grants alternate in1,in2,in1,in2 starting with in1. sel toggles 0,1,0,1. After 8 cycles grant_cnt1=grant_cnt2=4.
- Backpressure: load 0x5A from in2, then out_ready=0 for 3 cycles with both valid -> out_data=0x5A and sel=1 stable, readies 0, prio unchanged. On out_ready=1, in1 is granted the same cycle and 0x?? from in1 appears the next cycle.
- Counter wrap with CNT_W=2: 5 grants from in2 -> grant_cnt2 sequence 1,2,3,0,1.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, sel=0, counters 0. First post-reset contention is granted to in1.

Source files
------------

// File: rtl/rr_arbiter_2_to_1_if.sv
// Valid/ready stream bundle used for both arbiter inputs and its registered output.
interface rr_arbiter_2_to_1_if #(parameter int WIDTH = 8);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rr_arbiter_2_to_1.sv
// Two-source round-robin stream arbiter with a registered output word and the
// registered select that steers the downstream 2:1 mux.
module rr_arbiter_2_to_1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_arbiter_2_to_1_if.slave    in1,
  rr_arbiter_2_to_1_if.slave    in2,
  rr_arbiter_2_to_1_if.master   out,
  output logic                  sel,
  output logic [CNT_W-1:0]      grant_cnt1,
  output logic [CNT_W-1:0]      grant_cnt2
);

  logic [1:0]              vld, gnt, rdy, xfer;
  logic [1:0][WIDTH-1:0]   din;
  logic [1:0][CNT_W-1:0]   cnt;
  logic                    prio;
  logic                    out_vld;
  logic [WIDTH-1:0]        out_q;
  logic                    can_load;

  assign vld    = {in2.valid, in1.valid};
  assign din[0] = in1.data;
  assign din[1] = in2.data;

  // prio = 0 favours in1 only when both sources contend
  assign gnt[0]   = vld[0] && (!vld[1] || !prio);
  assign gnt[1]   = vld[1] && (!vld[0] ||  prio);
  assign can_load = !out_vld || out.ready;
  // readies are forced low during the reset cycle so nothing is accepted
  assign rdy      = {2{rst_n && can_load}} & gnt;
  assign xfer     = vld & rdy;

  assign in1.ready  = rdy[0];
  assign in2.ready  = rdy[1];
  assign out.valid  = out_vld;
  assign out.data   = out_q;
  assign grant_cnt1 = cnt[0];
  assign grant_cnt2 = cnt[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_q   <= '0;
      sel     <= 1'b0;
      prio    <= 1'b0;
      cnt     <= '0;
    end else begin
      if (|xfer) begin
        out_vld <= 1'b1;
        out_q   <= xfer[1] ? din[1] : din[0];
        sel     <= xfer[1];
        prio    <= xfer[0];
      end else if (out.ready) begin
        out_vld <= 1'b0;
      end
      for (int i = 0; i < 2; i++)
        cnt[i] <= cnt[i] + CNT_W'(xfer[i]);
    end
  end

endmodule

// File: tb/tb_rr_arbiter_2_to_1.sv
// Directed bench: one arbiter with 8-bit counters and one with 2-bit counters share stimulus.
module tb_rr_arbiter_2_to_1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in1_valid, in2_valid, out_ready;
  logic [7:0] in1_data, in2_data;
  logic       sel_a, sel_b;
  logic [7:0] c1_a, c2_a;
  logic [1:0] c1_b, c2_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  rr_arbiter_2_to_1_if #(.WIDTH(8)) in1_a(), in2_a(), out_a();
  rr_arbiter_2_to_1_if #(.WIDTH(8)) in1_b(), in2_b(), out_b();

  assign in1_a.valid = in1_valid;  assign in1_b.valid = in1_valid;
  assign in1_a.data  = in1_data;   assign in1_b.data  = in1_data;
  assign in2_a.valid = in2_valid;  assign in2_b.valid = in2_valid;
  assign in2_a.data  = in2_data;   assign in2_b.data  = in2_data;
  assign out_a.ready = out_ready;  assign out_b.ready = out_ready;

  rr_arbiter_2_to_1 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1_a), .in2(in2_a), .out(out_a),
    .sel(sel_a), .grant_cnt1(c1_a), .grant_cnt2(c2_a));

  rr_arbiter_2_to_1 #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in1(in1_b), .in2(in2_b), .out(out_b),
    .sel(sel_b), .grant_cnt1(c1_b), .grant_cnt2(c2_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic r1, input logic r2);
    #1;
    chk({tag, ".in1_ready"}, 32'(in1_a.ready), 32'(r1));
    chk({tag, ".in2_ready"}, 32'(in2_a.ready), 32'(r2));
    chk({tag, ".in1_ready_w"}, 32'(in1_b.ready), 32'(r1));
    chk({tag, ".in2_ready_w"}, 32'(in2_b.ready), 32'(r2));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".out_valid"}, 32'(out_a.valid), 32'(v));
    chk({tag, ".out_data"},  32'(out_a.data),  32'(d));
    chk({tag, ".sel"},       32'(sel_a),       32'(s));
    chk({tag, ".sel_w"},     32'(sel_b),       32'(s));
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [1:0] b1, input logic [1:0] b2);
    chk({tag, ".cnt1"},   32'(c1_a), 32'(a1));
    chk({tag, ".cnt2"},   32'(c2_a), 32'(a2));
    chk({tag, ".cnt1_w"}, 32'(c1_b), 32'(b1));
    chk({tag, ".cnt2_w"}, 32'(c2_b), 32'(b2));
  endtask

  initial begin
    // reset held two cycles with both sources requesting
    rst_n = 1'b0; in1_valid = 1'b1; in2_valid = 1'b1; out_ready = 1'b1;
    in1_data = 8'h01; in2_data = 8'h02;
    chk_rdy("rst0", 0, 0);
    tick();
    chk_rdy("rst1", 0, 0);
    tick();
    chk_out("rst", 0, 8'h00, 0);
    chk_cnt("rst", 0, 0, 0, 0);

    // contention: strict alternation starting with in1
    rst_n = 1'b1; in1_data = 8'hA0; in2_data = 8'hB0;
    for (int k = 0; k < 8; k++) begin
      chk_rdy($sformatf("cont%0d", k), (k % 2) == 0, (k % 2) == 1);
      tick();
      chk_out($sformatf("cont%0d", k), 1, (k % 2) ? 8'hB0 : 8'hA0, (k % 2) == 1);
    end
    chk_cnt("cont", 4, 4, 0, 0);

    // single source stream from in1
    in2_valid = 1'b0;
    in1_data = 8'h11; chk_rdy("s1a", 1, 0); tick(); chk_out("s1a", 1, 8'h11, 0);
    in1_data = 8'h22; chk_rdy("s1b", 1, 0); tick(); chk_out("s1b", 1, 8'h22, 0);
    in1_data = 8'h33; chk_rdy("s1c", 1, 0); tick(); chk_out("s1c", 1, 8'h33, 0);
    chk_cnt("s1", 7, 4, 3, 0);

    // drain without refill keeps data/sel
    in1_valid = 1'b0;
    chk_rdy("drain", 0, 0);
    tick();
    chk_out("drain", 0, 8'h33, 0);

    // load 0x5A from in2, then stall three cycles with both valid
    in2_valid = 1'b1; in2_data = 8'h5A;
    chk_rdy("ld5a", 0, 1); tick(); chk_out("ld5a", 1, 8'h5A, 1);
    chk_cnt("ld5a", 7, 5, 3, 1);
    out_ready = 1'b0; in1_valid = 1'b1; in1_data = 8'hC3; in2_data = 8'hD4;
    for (int k = 0; k < 3; k++) begin
      chk_rdy($sformatf("stall%0d", k), 0, 0);
      tick();
      chk_out($sformatf("stall%0d", k), 1, 8'h5A, 1);
    end
    chk_cnt("stall", 7, 5, 3, 1);
    out_ready = 1'b1;
    chk_rdy("unstall", 1, 0); tick(); chk_out("unstall", 1, 8'hC3, 0);
    chk_cnt("unstall", 8, 5, 0, 1);

    // reset while a word is stalled in the output register
    out_ready = 1'b0;
    chk_rdy("pre_mrst", 0, 0);
    rst_n = 1'b0; out_ready = 1'b1;
    chk_rdy("mrst", 0, 0);
    tick();
    chk_out("mrst", 0, 8'h00, 0);
    chk_cnt("mrst", 0, 0, 0, 0);
    rst_n = 1'b1; in1_data = 8'hE1; in2_data = 8'hF2;
    chk_rdy("post_rst", 1, 0); tick(); chk_out("post_rst", 1, 8'hE1, 0);
    chk_cnt("post_rst", 1, 0, 1, 0);

    // five in2 grants: narrow counter wraps 1,2,3,0,1
    in1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in2_data = 8'(8'h40 + k);
      chk_rdy($sformatf("wrap%0d", k), 0, 1);
      tick();
      chk_out($sformatf("wrap%0d", k), 1, 8'(8'h40 + k), 1);
      chk_cnt($sformatf("wrap%0d", k), 1, 8'(k + 1), 1, 2'(k + 1));
    end

    // last grant went to in2, so contention now favours in1
    in1_valid = 1'b1; in1_data = 8'h9E;
    chk_rdy("final", 1, 0); tick(); chk_out("final", 1, 8'h9E, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
